timer_counter: RTL and testbench



---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_counter.sv | 137 +++++++++++++
 tb/tb_timer_counter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the programmable down-counting timer:
// FSM state encoding, register word offsets, CTRL bit positions and MODE codes.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  // Word offsets inside the 16-byte register window (Addr[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_WIDTH   = 4;

  // MODE codes; the two unused codes behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Programmable 32-bit down-counting timer on the bridge device bus.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only). The FSM walks
// IDLE -> LOAD -> CNT -> INT and raises a level IRQ, maskable by IM.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  import timer_pkg::*;

  logic [CTRL_WIDTH-1:0] ctrl_reg;
  logic [31:0]           preset_reg;
  logic [31:0]           count_reg;
  logic [31:0]           count_next;
  logic                  irq_flag_reg;
  logic                  irq_flag_next;
  state_t                state_reg;
  state_t                state_next;

  logic       hit;
  logic [1:0] offset;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       en;
  logic       reload_mode;
  logic       en_clear;
  logic       flag_set;
  logic       flag_clr;

  assign hit         = (Addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = Addr[3:2];
  assign wr_ctrl     = WE && hit && (offset == OFF_CTRL);
  assign wr_preset   = WE && hit && (offset == OFF_PRESET);
  assign en          = ctrl_reg[CTRL_EN];
  assign reload_mode = (ctrl_reg[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  // Register file: CPU writes to CTRL take priority over the FSM's one-shot EN clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg   <= '0;
      preset_reg <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_reg <= Din[CTRL_WIDTH-1:0];
      end else if (en_clear) begin
        ctrl_reg[CTRL_EN] <= 1'b0;
      end
      if (wr_preset) begin
        preset_reg <= Din;
      end
    end
  end

  // FSM state, counter and interrupt flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      irq_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  // Next-state, counter and flag logic; a flag set in CNT beats a same-cycle register-write clear
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    en_clear   = 1'b0;
    flag_set   = 1'b0;
    flag_clr   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) state_next = LOAD;
      end
      LOAD: begin
        count_next = preset_reg;
        state_next = CNT;
      end
      CNT: begin
        if (!en) begin
          state_next = IDLE;
        end else if (count_reg <= 32'd1) begin
          // PRESET of 0 lands here too, so it times out like PRESET of 1
          count_next = '0;
          flag_set   = 1'b1;
          state_next = INT;
        end else begin
          count_next = count_reg - 32'd1;
        end
      end
      INT: begin
        state_next = IDLE;
        if (reload_mode) begin
          // EN stays set, so IDLE immediately reloads; the flag is a one-cycle pulse
          flag_clr = 1'b1;
        end else begin
          en_clear = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (flag_set) begin
      irq_flag_next = 1'b1;
    end else if (flag_clr || wr_ctrl || wr_preset) begin
      irq_flag_next = 1'b0;
    end else begin
      irq_flag_next = irq_flag_reg;
    end
  end

  // Combinational read mux; misses and the reserved word read as zero
  always_comb begin
    Dout = '0;
    if (hit) begin
      case (offset)
        OFF_CTRL:   Dout = {{(32-CTRL_WIDTH){1'b0}}, ctrl_reg};
        OFF_PRESET: Dout = preset_reg;
        OFF_COUNT:  Dout = count_reg;
        default:    Dout = '0;
      endcase
    end
  end

  assign IRQ = ctrl_reg[CTRL_IM] & irq_flag_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter (instance at 0x7F10). Expected values are
// pushed to a scoreboard queue as each check is issued and popped when the
// DUT output is sampled, 1 ns or more after the active clock edge.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [29:0] addr_w;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] A_CTRL   = 32'h7F10;
  localparam logic [31:0] A_PRESET = 32'h7F14;
  localparam logic [31:0] A_COUNT  = 32'h7F18;
  localparam logic [31:0] A_RSVD   = 32'h7F1C;

  timer_counter #(.BASE_ADDR(32'h0000_7F10)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (addr_w),
    .WE   (we),
    .Din  (din),
    .Dout (dout),
    .IRQ  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", t, obs, e);
      $error("check %s", t);
    end
    $display("check %-14s observed=0x%08h expected=0x%08h", t, obs, e);
  endtask

  task automatic set_addr(input logic [31:0] byte_addr);
    addr_w = byte_addr[31:2];
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write; returns 1 ns after the edge where it took effect
  task automatic wr(input logic [31:0] byte_addr, input logic [31:0] data);
    set_addr(byte_addr);
    we  = 1'b1;
    din = data;
    @(posedge clk);
    #1;
    we  = 1'b0;
    din = '0;
  endtask

  task automatic rd(input string tag, input logic [31:0] byte_addr, input logic [31:0] e);
    set_addr(byte_addr);
    push_exp(tag, e);
    #1;
    pop_cmp(dout);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    push_exp(tag, {31'b0, e});
    pop_cmp({31'b0, irq});
  endtask

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    din    = '0;
    addr_w = '0;

    // Power-on reset values
    #1;
    chk_irq("por_irq", 1'b0);
    rd("por_ctrl",   A_CTRL,   32'h0);
    rd("por_preset", A_PRESET, 32'h0);
    rd("por_count",  A_COUNT,  32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset mid-count at COUNT=7
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    repeat (5) tick();
    rd("pre_rst_count", A_COUNT, 32'd7);
    #2 reset = 1'b1;
    #1;
    chk_irq("rst_irq", 1'b0);
    rd("rst_ctrl",   A_CTRL,   32'h0);
    rd("rst_preset", A_PRESET, 32'h0);
    rd("rst_count",  A_COUNT,  32'h0);
    @(negedge clk);
    reset = 1'b0;

    // One-shot: PRESET=5, EN|IM at t0; IRQ after t0+7
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      rd("os_count", A_COUNT, 32'(5 - k));
      chk_irq("os_irq_lo", 1'b0);
      tick();
    end
    chk_irq("os_irq_hi", 1'b1);
    rd("os_count0", A_COUNT, 32'd0);
    tick();
    rd("os_ctrl_en0", A_CTRL, 32'h8);
    repeat (3) tick();
    chk_irq("os_irq_hold", 1'b1);
    wr(A_CTRL, 32'h0);
    chk_irq("os_irq_clr", 1'b0);

    // Auto-reload: PRESET=3 -> one-cycle pulse every 6 cycles
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      tick();
      chk_irq("ar_irq", (k >= 5) && (((k - 5) % 6) == 0));
    end
    wr(A_CTRL, 32'h3);
    for (int k = 0; k < 20; k++) begin
      chk_irq("ar_masked", 1'b0);
      tick();
    end
    wr(A_CTRL, 32'h0);
    repeat (3) tick();

    // Stop/restart: the stopping write edge still decrements 10 -> 9, then frozen
    wr(A_PRESET, 32'd20);
    wr(A_CTRL, 32'h9);
    repeat (12) tick();
    rd("sr_count10", A_COUNT, 32'd10);
    wr(A_CTRL, 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick();
      rd("sr_frozen", A_COUNT, 32'd9);
    end
    wr(A_CTRL, 32'h9);
    rd("sr_idle", A_COUNT, 32'd9);
    tick();
    rd("sr_load", A_COUNT, 32'd9);
    tick();
    rd("sr_reload", A_COUNT, 32'd20);
    // PRESET write mid-count only affects the next LOAD
    wr(A_PRESET, 32'd50);
    rd("sr_pre_mid", A_COUNT, 32'd19);
    rd("sr_preset50", A_PRESET, 32'd50);
    wr(A_CTRL, 32'h0);
    tick();
    tick();
    rd("sr_stopped", A_COUNT, 32'd18);

    // Address decode for the instance at 0x7F10
    wr(32'h7F14, 32'h1234);
    rd("dec_preset", A_PRESET, 32'h1234);
    wr(32'h7F18, 32'hFFFF_FFFF);
    rd("dec_count_ro", A_COUNT, 32'd18);
    wr(32'h7F04, 32'hDEAD);
    rd("dec_miss_wr", A_PRESET, 32'h1234);
    wr(32'h7F00, 32'h9);
    rd("dec_miss_ctrl", A_CTRL, 32'h0);
    rd("dec_rsvd", A_RSVD, 32'h0);
    rd("dec_miss_rd0", 32'h7F00, 32'h0);
    rd("dec_miss_rd1", 32'h7F04, 32'h0);

    // PRESET=0 behaves as 1: IRQ after t0+3
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h9);
    tick();
    tick();
    chk_irq("p0_irq_lo", 1'b0);
    tick();
    chk_irq("p0_irq_hi", 1'b1);
    tick();
    rd("p0_ctrl", A_CTRL, 32'h8);
    wr(A_CTRL, 32'h0);
    chk_irq("p0_irq_clr", 1'b0);

    // PRESET write on the flag-setting edge: set wins
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    tick();
    tick();
    rd("sw_count2", A_COUNT, 32'd2);
    tick();
    wr(A_PRESET, 32'd7);
    chk_irq("sw_set_wins", 1'b1);
    rd("sw_preset7", A_PRESET, 32'd7);
    // CTRL write in INT beats the FSM's own EN clear
    wr(A_CTRL, 32'h9);
    rd("sw_cpu_wins", A_CTRL, 32'h9);
    chk_irq("sw_irq_clr", 1'b0);
    tick();
    tick();
    rd("sw_reload7", A_COUNT, 32'd7);
    wr(A_CTRL, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
